// File: rtl/icache_refill_ctrl_pkg.sv
// Shared definitions for the instruction-cache refill controller.
// Optional feature macro: ICACHE_NEXT_LINE_PREFETCH_EN (next-line prefetch).
package icache_refill_ctrl_pkg;

  // Controller states; PF_* states are only reachable with prefetch built in
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_REQ     = 3'd1;
  localparam state_t ST_FILL    = 3'd2;
  localparam state_t ST_RETRY   = 3'd3;
  localparam state_t ST_PF_REQ  = 3'd4;
  localparam state_t ST_PF_HOLD = 3'd5;

  // Byte-offset bits inside one cache line (16-byte lines)
  localparam int LINE_OFF = 4;

  // Default memory-ack timeout in cycles
  localparam int TMO_CYC_DEFAULT = 255;

  // Value of the wait counter on the last allowed non-ack cycle
  function automatic logic [7:0] tmo_last(input int tmo);
    return 8'(tmo - 1);
  endfunction

endpackage

// File: rtl/icache_line_buf.sv
// One line-sized holding register: address, data and valid flag,
// plus an address compare against a line-aligned lookup address.
module icache_line_buf #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_addr_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_data_we,
  input  logic [LINE_W-1:0] i_data,
  input  logic [ADDR_W-1:0] i_cmp_addr,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_addr,
  output logic [LINE_W-1:0] o_data,
  output logic              o_match
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_data;

  // Loading a new address invalidates old data; data arrival marks the line valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end else if (i_addr_we) begin
      r_addr  <= i_addr;
      r_valid <= 1'b0;
    end else if (i_data_we) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end
  end

  assign o_valid = r_valid;
  assign o_addr  = r_addr;
  assign o_data  = r_data;
  assign o_match = r_valid && (r_addr == i_cmp_addr);

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss/refill controller: stalls fetch on a miss, reads one
// line from memory with a timeout/retry, and writes it into the cache.
// Optional feature macro: ICACHE_NEXT_LINE_PREFETCH_EN adds a one-line
// next-line prefetch buffer serviced without stalling the pipeline.
module icache_refill_ctrl
  import icache_refill_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 128,
  parameter int TMO_CYC = TMO_CYC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic              i_hit,
  input  logic              i_redirect,
  output logic              o_stall,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_ack,
  input  logic [LINE_W-1:0] i_mem_data,
  output logic              o_fill_we,
  output logic [ADDR_W-1:0] o_fill_addr,
  output logic [LINE_W-1:0] o_fill_data,
  output logic              o_err
);

  localparam logic [ADDR_W-1:0] LINE_MASK  = {{(ADDR_W-LINE_OFF){1'b1}}, {LINE_OFF{1'b0}}};
  localparam logic [ADDR_W-1:0] LINE_BYTES = ADDR_W'(1 << LINE_OFF);
  localparam logic [7:0]        TMO_LAST   = tmo_last(TMO_CYC);

  state_t            r_state;
  state_t            w_next;
  logic [7:0]        r_wait_cnt;
  logic              r_err;

  logic [ADDR_W-1:0] w_pc_line;
  logic              w_miss;
  logic              w_req_state;
  logic              w_wait_done;
  logic              w_stall;

  logic              w_cap_addr_we;
  logic              w_cap_data_we;
  logic              w_cap_clr;
  logic              w_cap_valid;
  logic [ADDR_W-1:0] w_cap_addr;
  logic [LINE_W-1:0] w_cap_data;
  logic              w_unused_cap_match;

  assign w_pc_line   = i_pc & LINE_MASK;
  assign w_miss      = !i_hit && !i_redirect;
  assign w_req_state = (r_state == ST_REQ) || (r_state == ST_PF_REQ);
  assign w_wait_done = !i_mem_ack && (r_wait_cnt == TMO_LAST);

  icache_line_buf #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) u_cap_buf (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_cap_clr),
    .i_addr_we  (w_cap_addr_we),
    .i_addr     (w_pc_line),
    .i_data_we  (w_cap_data_we),
    .i_data     (i_mem_data),
    .i_cmp_addr (w_pc_line),
    .o_valid    (w_cap_valid),
    .o_addr     (w_cap_addr),
    .o_data     (w_cap_data),
    .o_match    (w_unused_cap_match)
  );

`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
  logic              w_pf_addr_we;
  logic              w_pf_data_we;
  logic              w_pf_clr;
  logic              w_pf_hit;
  logic              w_unused_pf_valid;
  logic              w_pf_match;
  logic [ADDR_W-1:0] w_pf_addr_in;
  logic [ADDR_W-1:0] w_pf_addr;
  logic [LINE_W-1:0] w_pf_data;

  icache_line_buf #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) u_pf_buf (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_pf_clr),
    .i_addr_we  (w_pf_addr_we),
    .i_addr     (w_pf_addr_in),
    .i_data_we  (w_pf_data_we),
    .i_data     (i_mem_data),
    .i_cmp_addr (w_pc_line),
    .o_valid    (w_unused_pf_valid),
    .o_addr     (w_pf_addr),
    .o_data     (w_pf_data),
    .o_match    (w_pf_match)
  );
`endif

  // Next-state and buffer-load decode; a redirect never cancels an issued request
  always_comb begin
    w_next        = r_state;
    w_cap_addr_we = 1'b0;
    w_cap_data_we = 1'b0;
    w_cap_clr     = 1'b0;
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
    w_pf_addr_we  = 1'b0;
    w_pf_data_we  = 1'b0;
    w_pf_clr      = 1'b0;
    w_pf_hit      = 1'b0;
    w_pf_addr_in  = w_cap_addr + LINE_BYTES;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_miss) begin
          w_cap_addr_we = 1'b1;
          w_next        = ST_REQ;
        end
      end
      ST_REQ: begin
        if (i_mem_ack) begin
          w_cap_data_we = 1'b1;
          w_next        = ST_FILL;
        end else if (w_wait_done) begin
          w_next = ST_RETRY;
        end
      end
      ST_RETRY: w_next = ST_REQ;
      ST_FILL: begin
        w_cap_clr = 1'b1;
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
        w_pf_addr_we = 1'b1;
        w_next       = ST_PF_REQ;
`else
        w_next = ST_IDLE;
`endif
      end
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
      ST_PF_REQ: begin
        if (i_mem_ack) begin
          w_pf_data_we = 1'b1;
          w_next       = ST_PF_HOLD;
        end else if (w_wait_done) begin
          w_pf_clr = 1'b1;
          w_next   = ST_IDLE;
        end
      end
      ST_PF_HOLD: begin
        if (i_redirect) begin
          w_pf_clr = 1'b1;
          w_next   = ST_IDLE;
        end else if (!i_hit) begin
          if (w_pf_match) begin
            w_pf_hit     = 1'b1;
            w_pf_addr_we = 1'b1;
            w_pf_addr_in = w_pf_addr + LINE_BYTES;
            w_next       = ST_PF_REQ;
          end else begin
            w_pf_clr      = 1'b1;
            w_cap_addr_we = 1'b1;
            w_next        = ST_REQ;
          end
        end
      end
`endif
      default: w_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Wait counter restarts on every fresh request and counts cycles without ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= 8'd0;
    end else if ((w_next == ST_REQ && r_state != ST_REQ) ||
                 (w_next == ST_PF_REQ && r_state != ST_PF_REQ)) begin
      r_wait_cnt <= 8'd0;
    end else if (w_req_state && !i_mem_ack) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  // Sticky timeout flag, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            r_err <= 1'b0;
    else if (w_req_state && w_wait_done) r_err <= 1'b1;
  end

  // Fetch stall: idle-like states stall only on a live miss, all others always
  always_comb begin
    case (r_state)
      ST_IDLE, ST_PF_REQ, ST_PF_HOLD: w_stall = w_miss;
      default:                        w_stall = 1'b1;
    endcase
  end

  assign o_stall   = w_stall && !rst;
  assign o_mem_req = w_req_state;
  assign o_err     = r_err;

`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
  assign o_mem_addr  = (r_state == ST_PF_REQ) ? w_pf_addr : w_cap_addr;
  assign o_fill_we   = ((r_state == ST_FILL) && w_cap_valid) || w_pf_hit;
  assign o_fill_addr = w_pf_hit ? w_pf_addr : w_cap_addr;
  assign o_fill_data = w_pf_hit ? w_pf_data : w_cap_data;
`else
  assign o_mem_addr  = w_cap_addr;
  assign o_fill_we   = (r_state == ST_FILL) && w_cap_valid;
  assign o_fill_addr = w_cap_addr;
  assign o_fill_data = w_cap_data;
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed self-checking bench for icache_refill_ctrl (TMO_CYC = 4).
// Prefetch scenarios run when ICACHE_NEXT_LINE_PREFETCH_EN is defined.
module tb_icache_refill_ctrl;

  localparam int ADDR_W  = 32;
  localparam int LINE_W  = 128;
  localparam int TMO_CYC = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] i_pc;
  logic              i_hit;
  logic              i_redirect;
  logic              o_stall;
  logic              o_mem_req;
  logic [ADDR_W-1:0] o_mem_addr;
  logic              i_mem_ack;
  logic [LINE_W-1:0] i_mem_data;
  logic              o_fill_we;
  logic [ADDR_W-1:0] o_fill_addr;
  logic [LINE_W-1:0] o_fill_data;
  logic              o_err;

  int vectors     = 0;
  int miscompares = 0;
  int stallSeen   = 0;

  icache_refill_ctrl #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TMO_CYC(TMO_CYC)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_pc        (i_pc),
    .i_hit       (i_hit),
    .i_redirect  (i_redirect),
    .o_stall     (o_stall),
    .o_mem_req   (o_mem_req),
    .o_mem_addr  (o_mem_addr),
    .i_mem_ack   (i_mem_ack),
    .i_mem_data  (i_mem_data),
    .o_fill_we   (o_fill_we),
    .o_fill_addr (o_fill_addr),
    .o_fill_data (o_fill_data),
    .o_err       (o_err)
  );

  // 10-unit clock
  always #5 clk = ~clk;

  // Inputs change in the low phase; outputs are looked at 1 unit later
  task automatic applyStimulus(input logic hit, input logic redirect, input logic [31:0] pc,
                               input logic ack, input logic [127:0] data);
    i_hit      = hit;
    i_redirect = redirect;
    i_pc       = pc;
    i_mem_ack  = ack;
    i_mem_data = data;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkBit(input string tag, input logic observed, input logic expected);
    checkOutput(tag, {127'd0, observed}, {127'd0, expected});
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  localparam logic [127:0] DATA_A5 = {16{8'hA5}};
  localparam logic [127:0] DATA_C  = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
  localparam logic [127:0] DATA_D  = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
  localparam logic [127:0] DATA_E  = 128'hCAFE_F00D_CAFE_F00D_CAFE_F00D_CAFE_F00D;

  initial begin
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, '0);
    #1;
    checkBit("rst_stall", o_stall, 1'b0);
    checkBit("rst_mem_req", o_mem_req, 1'b0);
    checkBit("rst_fill_we", o_fill_we, 1'b0);
    checkBit("rst_err", o_err, 1'b0);
    checkOutput("rst_mem_addr", {96'd0, o_mem_addr}, 128'd0);
    checkOutput("rst_fill_data", o_fill_data, 128'd0);
    nextCycle();
    rst = 1'b0;

`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
    $display("[TB] prefetch build: miss 0x200 then 0x210");
    applyStimulus(1'b0, 1'b0, 32'h0000_0200, 1'b0, '0);
    checkBit("pf_miss_stall", o_stall, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0000_0200, 1'b1, DATA_A5);
    checkOutput("pf_req_addr", {96'd0, o_mem_addr}, 128'h200);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0000_0200, 1'b0, '0);
    checkBit("pf_fill_we", o_fill_we, 1'b1);
    checkOutput("pf_fill_data", o_fill_data, DATA_A5);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h0000_0204, 1'b1, DATA_C);
    checkBit("pf_req_nostall", o_stall, 1'b0);
    checkBit("pf_req_active", o_mem_req, 1'b1);
    checkOutput("pf_req_next_addr", {96'd0, o_mem_addr}, 128'h210);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0000_0210, 1'b0, '0);
    stallSeen = 0;
    if (o_stall) stallSeen++;
    checkBit("pf_hold_fill_we", o_fill_we, 1'b1);
    checkOutput("pf_hold_fill_addr", {96'd0, o_fill_addr}, 128'h210);
    checkOutput("pf_hold_fill_data", o_fill_data, DATA_C);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h0000_0214, 1'b1, DATA_D);
    if (o_stall) stallSeen++;
    checkOutput("pf_buf_stall_cycles", 128'(stallSeen), 128'd1);
    checkOutput("pf_chain_addr", {96'd0, o_mem_addr}, 128'h220);
    nextCycle();
    $display("[TB] prefetch build: wrap at top of address space");
    applyStimulus(1'b0, 1'b0, 32'hFFFF_FFF4, 1'b0, '0);
    checkBit("pf_nomatch_stall", o_stall, 1'b1);
    checkBit("pf_nomatch_fill_we", o_fill_we, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'hFFFF_FFF4, 1'b1, DATA_E);
    checkOutput("wrap_req_addr", {96'd0, o_mem_addr}, 128'hFFFF_FFF0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'hFFFF_FFF4, 1'b0, '0);
    checkOutput("wrap_fill_addr", {96'd0, o_fill_addr}, 128'hFFFF_FFF0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'hFFFF_FFF8, 1'b0, '0);
    checkBit("wrap_pf_req", o_mem_req, 1'b1);
    checkOutput("wrap_pf_addr", {96'd0, o_mem_addr}, 128'h0);
    nextCycle();
`else
    $display("[TB] miss at 0x104, two wait cycles");
    stallSeen = 0;
    applyStimulus(1'b0, 1'b0, 32'h0000_0104, 1'b0, '0);
    if (o_stall) stallSeen++;
    checkBit("a_detect_req", o_mem_req, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0000_0104, 1'b0, '0);
    if (o_stall) stallSeen++;
    checkBit("a_req", o_mem_req, 1'b1);
    checkOutput("a_req_addr", {96'd0, o_mem_addr}, 128'h100);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0000_0104, 1'b0, '0);
    if (o_stall) stallSeen++;
    checkOutput("a_req_addr_stable", {96'd0, o_mem_addr}, 128'h100);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0000_0104, 1'b1, DATA_A5);
    if (o_stall) stallSeen++;
    checkBit("a_ack_no_fill", o_fill_we, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0000_0104, 1'b0, '0);
    if (o_stall) stallSeen++;
    checkBit("a_fill_we", o_fill_we, 1'b1);
    checkOutput("a_fill_addr", {96'd0, o_fill_addr}, 128'h100);
    checkOutput("a_fill_data", o_fill_data, DATA_A5);
    checkBit("a_fill_no_req", o_mem_req, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h0000_0104, 1'b0, '0);
    checkOutput("a_stall_cycles", 128'(stallSeen), 128'd5);
    checkBit("a_idle_stall", o_stall, 1'b0);
    checkBit("a_idle_fill_we", o_fill_we, 1'b0);
    nextCycle();

    $display("[TB] miss squashed by simultaneous redirect");
    applyStimulus(1'b0, 1'b1, 32'h0000_0300, 1'b0, '0);
    checkBit("b_squash_stall", o_stall, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h0000_0800, 1'b0, '0);
    checkBit("b_no_req", o_mem_req, 1'b0);
    checkBit("b_no_stall", o_stall, 1'b0);
    nextCycle();

    $display("[TB] redirect one cycle into REQ");
    applyStimulus(1'b0, 1'b0, 32'h0000_02C8, 1'b0, '0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 32'h0000_02C8, 1'b0, '0);
    checkBit("c_redirect_req_held", o_mem_req, 1'b1);
    checkBit("c_redirect_stall", o_stall, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0000_0900, 1'b1, DATA_C);
    checkOutput("c_req_addr", {96'd0, o_mem_addr}, 128'h2C0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0000_0900, 1'b0, '0);
    checkBit("c_fill_we", o_fill_we, 1'b1);
    checkOutput("c_fill_addr", {96'd0, o_fill_addr}, 128'h2C0);
    checkOutput("c_fill_data", o_fill_data, DATA_C);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h0000_0900, 1'b0, '0);
    checkBit("c_idle_req", o_mem_req, 1'b0);
    checkBit("c_idle_stall", o_stall, 1'b0);
    nextCycle();

    $display("[TB] timeout with TMO_CYC=4");
    applyStimulus(1'b0, 1'b0, 32'h0000_0404, 1'b0, '0);
    nextCycle();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0000_0404, 1'b0, '0);
      checkBit("d_wait_req", o_mem_req, 1'b1);
      checkBit("d_wait_err", o_err, 1'b0);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 32'h0000_0404, 1'b0, '0);
    checkBit("d_err_set", o_err, 1'b1);
    checkBit("d_drop_req", o_mem_req, 1'b0);
    checkBit("d_drop_stall", o_stall, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0000_0404, 1'b1, DATA_D);
    checkBit("d_retry_req", o_mem_req, 1'b1);
    checkOutput("d_retry_addr", {96'd0, o_mem_addr}, 128'h400);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0000_0404, 1'b0, '0);
    checkOutput("d_fill_data", o_fill_data, DATA_D);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h0000_0404, 1'b0, '0);
    checkBit("d_err_sticky", o_err, 1'b1);
    nextCycle();

    $display("[TB] reset pulse mid-REQ");
    applyStimulus(1'b0, 1'b0, 32'h0000_0504, 1'b0, '0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0000_0504, 1'b0, '0);
    checkBit("e_req_before_rst", o_mem_req, 1'b1);
    rst = 1'b1;
    #1;
    checkBit("e_rst_req", o_mem_req, 1'b0);
    checkBit("e_rst_stall", o_stall, 1'b0);
    checkBit("e_rst_err", o_err, 1'b0);
    checkOutput("e_rst_addr", {96'd0, o_mem_addr}, 128'h0);
    nextCycle();
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h0000_0504, 1'b1, DATA_E);
    checkBit("e_late_ack_req", o_mem_req, 1'b0);
    checkBit("e_late_ack_fill", o_fill_we, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h0000_0504, 1'b0, '0);
    checkBit("e_after_ack_fill", o_fill_we, 1'b0);
    checkBit("e_after_ack_stall", o_stall, 1'b0);
    nextCycle();
`endif

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
